kw_fifo_pop_stage: RTL and testbench
====================================

# kw_fifo_pop_stage

Pop-side adapter between a FIFO controller (req/flag interface, RAM-backed read data) and a valid/ready stream consumer. It issues pop requests against the controller's `empty` flag and absorbs a fixed RAM read latency. A small output buffer sustains one word per cycle despite that latency. Output data is always driven from a register, so the consumer never sees RAM timing.

## Interface
- `DATA_WIDTH`, 16, data width in bits
- `READ_LATENCY`, 1, cycles from a pop request to its word appearing on `fifo_data`; legal values are 0, 1, 2
- `BUF_DEPTH`, `READ_LATENCY+1`, output buffer entries; do not change
- `clock` input 1 single clock, rising edge
- `reset_n` input 1 reset, asynchronous, active-low
- `fifo_empty` input 1 controller empty flag
- `fifo_pop_req` output 1 pop request to controller
- `fifo_data` input `DATA_WIDTH` controller read data (`data_o`)
- `m_valid` output 1 output word valid
- `m_ready` input 1 consumer ready
- `m_data` output `DATA_WIDTH` output word (registered)
- `buf_count` output `$clog2(BUF_DEPTH+1)` words currently held in the buffer
- `inflight` output 2 pops issued whose data has not yet been captured

## Operation
- State:
  - In-flight tracker: a `READ_LATENCY`-stage shift register of pop-valid bits; `inflight` is its popcount.
  - Circular buffer of `BUF_DEPTH` entries with read pointer, write pointer and count.
- Accept: `take = m_valid && m_ready` removes the head entry.
- Issue: `fifo_pop_req = !fifo_empty && (buf_count + inflight - take) < BUF_DEPTH`.
  - This is combinational from `m_ready` and `fifo_empty`.
  - It never issues when the buffer plus in-flight words, net of this cycle's take, would exceed `BUF_DEPTH`.
- Capture:
  - `READ_LATENCY`=0: `fifo_data` is written into the buffer at the same edge as the pop.
  - `READ_LATENCY`=L>0: `fifo_data` is written at the edge ending cycle t+L for a pop issued in cycle t.
- Buffer update per edge: `count_next = count + capture - take`. Simultaneous capture and take are legal in any state, including full-with-take and empty-with-capture.
- `m_valid = (buf_count != 0)`; `m_data` = head entry.
- Order is strictly preserved: words leave in the order their pops were issued.
- Pointers wrap modulo `BUF_DEPTH`. When `BUF_DEPTH` is not a power of two, wrap explicitly at `BUF_DEPTH-1 -> 0`.
- Overflow is impossible by construction. The bench asserts `buf_count + inflight <= BUF_DEPTH` every cycle.
- Underflow of the controller is impossible: no pop is issued while `fifo_empty` is high.

## Timing
- Reset values:
  - `buf_count`=0, `inflight`=0, `m_valid`=0, pointers=0.
  - `m_data`=0 (buffer storage is also reset).
  - `fifo_pop_req` is 0 while `reset_n` is low.
- Reset mid-operation clears all in-flight and buffered words immediately (asynchronous). The controller must share the same reset; words in flight are lost.
- Latency: a pop issued in cycle t gives `m_valid`=1 with that word in cycle t+`READ_LATENCY`+1.
- Throughput: with `m_ready` held high and the FIFO non-empty, one pop and one output word per cycle in steady state.
- `m_valid` and `m_data` are stable while `m_valid && !m_ready`. They change only at an edge where take=1 or `buf_count` was 0.
- `fifo_empty` is sampled in the same cycle the pop is issued. The controller updates its count at that edge, so back-to-back pops on a one-entry FIFO cannot occur.

## Test plan
- **Latency check:** `READ_LATENCY`=1; FIFO holds 0xA5A5; `m_ready`=1.
  - Required: pop at cycle 0, `m_valid` at cycle 2 with `m_data`=0xA5A5, then `fifo_pop_req`=0.
- **Streaming:** `READ_LATENCY`=2; 16 words 0..15 preloaded; `m_ready`=1.
  - Required: `fifo_pop_req` high for 16 consecutive cycles; outputs 0..15 on consecutive cycles starting at cycle 3.
- **Backpressure:** `READ_LATENCY`=1; 8 words; `m_ready`=0 for 10 cycles, then 1.
  - Required: exactly 2 pops issued, `buf_count`=2, `m_data`=word0 held stable throughout.
  - After release: words 0..7 in order with no gaps.
- **Empty boundary:** `fifo_empty`=1 with `m_ready`=1.
  - Required: no pops, `m_valid`=0.
  - One push arrives: exactly one pop; `m_valid` pulses for 1 cycle with that word.
- **Random ready:** `READ_LATENCY`=0; `m_ready` random at 50%; 200 words.
  - Required: output sequence equals input sequence; `buf_count + inflight <= BUF_DEPTH` every cycle.
- **Reset mid-stream:** `READ_LATENCY`=2; 2 pops in flight, `buf_count`=1; `reset_n` low for 1 cycle.
  - Required: `m_valid`=0, `buf_count`=0, `inflight`=0 immediately.
  - No stale word emitted after release.

Source files
------------

// File: rtl/kw_fifo_pop_stage.sv
// Pop-side adapter: issues FIFO pops against the empty flag, absorbs the RAM read
// latency in a small circular buffer and presents a registered valid/ready stream.
module kw_fifo_pop_stage #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BUF_DEPTH    = READ_LATENCY + 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               fifo_empty,
    output logic                               fifo_pop_req,
    input  logic [DATA_WIDTH-1:0]              fifo_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count,
    output logic [1:0]                         inflight
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned SW = 4;

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_head;

    logic                  w_take;
    logic                  w_pop;
    logic                  w_capture;
    logic [1:0]            w_inflight;
    logic [SW-1:0]         w_occ_net;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // In-flight tracker: one pop-valid bit per cycle of read latency
    if (READ_LATENCY == 0) begin : g_lat0
        assign w_capture  = w_pop;
        assign w_inflight = 2'd0;
    end else begin : g_latn
        logic [READ_LATENCY-1:0] r_pend;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_pend <= '0;
            end else begin
                r_pend <= READ_LATENCY'({r_pend, w_pop});
            end
        end

        assign w_capture = r_pend[READ_LATENCY-1];

        always_comb begin
            w_inflight = 2'd0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                w_inflight = w_inflight + 2'(r_pend[i]);
            end
        end
    end

    // Pop only if the word is guaranteed a buffer slot once it lands
    assign w_take    = r_valid & m_ready;
    assign w_occ_net = SW'(r_count) + SW'(w_inflight) - SW'(w_take);
    assign w_pop     = reset_n & ~fifo_empty & (w_occ_net < SW'(BUF_DEPTH));

    assign w_rd_ptr_nxt = w_take    ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_wr_ptr_nxt = w_capture ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    assign w_count_nxt  = r_count + CW'(w_capture) - CW'(w_take);

    // Next head comes straight from the capture path when it lands on the new head slot
    assign w_head_nxt = (w_capture && (r_wr_ptr == w_rd_ptr_nxt)) ? fifo_data
                                                                   : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_capture) begin
                r_mem[r_wr_ptr] <= fifo_data;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_head   <= w_head_nxt;
        end
    end

    assign fifo_pop_req = w_pop;
    assign m_valid      = r_valid;
    assign m_data       = r_head;
    assign buf_count    = r_count;
    assign inflight     = w_inflight;

endmodule

// File: tb/tb_kw_fifo_pop_stage.sv
// Bench for kw_fifo_pop_stage: three instances (read latency 0, 1, 2) driven by a
// behavioural FIFO controller, an occupancy model and an in-order scoreboard.
module tb_kw_fifo_pop_stage;

    localparam int unsigned DW = 16;
    localparam int          NI = 3;
    localparam int          MW = 1024;
    localparam logic [DW-1:0] DEAD = 16'hDEAD;

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] fifo_empty;
    logic [NI-1:0] pop_req;
    logic [NI-1:0] m_valid;
    logic [NI-1:0] m_ready;
    logic [DW-1:0] fifo_data [NI];
    logic [DW-1:0] m_data    [NI];
    logic [1:0]    buf_cnt   [NI];
    logic [1:0]    infl      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned CW = $clog2(g + 2);
        logic [CW-1:0] bc;
        kw_fifo_pop_stage #(.DATA_WIDTH(DW), .READ_LATENCY(g)) u_dut (
            .clock       (clk),
            .reset_n     (rst_n),
            .fifo_empty  (fifo_empty[g]),
            .fifo_pop_req(pop_req[g]),
            .fifo_data   (fifo_data[g]),
            .m_valid     (m_valid[g]),
            .m_ready     (m_ready[g]),
            .m_data      (m_data[g]),
            .buf_count   (bc),
            .inflight    (infl[g])
        );
        assign buf_cnt[g] = 2'(bc);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Controller model and reference state
    logic [DW-1:0] mem [NI][MW];
    int            head [NI];
    int            tail [NI];
    int            out_idx [NI];
    int            occ [NI];
    logic          h0 [NI];
    logic          h1 [NI];
    logic [DW-1:0] s1 [NI];
    logic [DW-1:0] s2 [NI];
    logic          hold [NI];
    logic [DW-1:0] prev_d [NI];
    logic          smp_pop [NI];
    logic          smp_take [NI];
    logic          smp_v [NI];
    logic [DW-1:0] smp_d [NI];

    typedef struct {
        logic          rdy;
        logic          pop;
        logic          vld;
        logic [DW-1:0] dat;
        int            cnt;
    } vec_t;
    vec_t tv [19];

    task automatic check(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic drive_ctrl();
        for (int k = 0; k < NI; k++) begin
            fifo_empty[k] = (head[k] == tail[k]);
            if (k == 0) fifo_data[k] = fifo_empty[k] ? DEAD : mem[k][head[k] % MW];
            else if (k == 1) fifo_data[k] = s1[k];
            else fifo_data[k] = s2[k];
        end
    endtask

    task automatic push(input int k, input logic [DW-1:0] w);
        mem[k][tail[k] % MW] = w;
        tail[k]++;
        drive_ctrl();
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            head[k]    = tail[k];
            out_idx[k] = tail[k];
            occ[k]     = 0;
            h0[k]      = 1'b0;
            h1[k]      = 1'b0;
            s1[k]      = DEAD;
            s2[k]      = DEAD;
            hold[k]    = 1'b0;
        end
        drive_ctrl();
    endtask

    // One clock: check every instance mid-cycle, then advance the controller model
    task automatic tick();
        int inf_e, bc_e, pop_e, v_e;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            inf_e = (k >= 1 ? int'(h0[k]) : 0) + (k >= 2 ? int'(h1[k]) : 0);
            bc_e  = occ[k] - inf_e;
            v_e   = (bc_e != 0) ? 1 : 0;
            pop_e = (!fifo_empty[k] && (occ[k] - (v_e & int'(m_ready[k]))) < k + 1) ? 1 : 0;
            check("inflight", k, int'(infl[k]), inf_e);
            check("buf_count", k, int'(buf_cnt[k]), bc_e);
            check("m_valid", k, int'(m_valid[k]), v_e);
            check("pop_req", k, int'(pop_req[k]), pop_e);
            check("occupancy_bound", k, (int'(buf_cnt[k]) + int'(infl[k]) <= k + 1) ? 1 : 0, 1);
            if (hold[k]) check("stable_data", k, int'(m_data[k]), int'(prev_d[k]));
            smp_take[k] = m_valid[k] & m_ready[k];
            if (smp_take[k]) begin
                check("extra_word", k, (out_idx[k] < tail[k]) ? 1 : 0, 1);
                check("order_data", k, int'(m_data[k]), int'(mem[k][out_idx[k] % MW]));
                out_idx[k]++;
            end
            hold[k]    = m_valid[k] & ~m_ready[k];
            prev_d[k]  = m_data[k];
            smp_pop[k] = pop_req[k];
            smp_v[k]   = m_valid[k];
            smp_d[k]   = m_data[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            s2[k] = s1[k];
            s1[k] = smp_pop[k] ? mem[k][head[k] % MW] : DEAD;
            if (smp_pop[k] && head[k] < tail[k]) head[k]++;
            h1[k]  = h0[k];
            h0[k]  = smp_pop[k];
            occ[k] = occ[k] + int'(smp_pop[k]) - int'(smp_take[k]);
        end
        drive_ctrl();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_valid", k, int'(m_valid[k]), 0);
            check("rst_buf_count", k, int'(buf_cnt[k]), 0);
            check("rst_inflight", k, int'(infl[k]), 0);
            check("rst_pop_req", k, int'(pop_req[k]), 0);
            check("rst_data", k, int'(m_data[k]), 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        bit done;
        int pushed [NI];

        // Backpressure vectors for the latency-1 instance, words 0x0B00..0x0B07
        tv[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 1};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 16'h0B00, 2};
        tv[10] = '{1'b1, 1'b1, 1'b1, 16'h0B00, 2};
        tv[11] = '{1'b1, 1'b1, 1'b1, 16'h0B01, 1};
        tv[12] = '{1'b1, 1'b1, 1'b1, 16'h0B02, 1};
        tv[13] = '{1'b1, 1'b1, 1'b1, 16'h0B03, 1};
        tv[14] = '{1'b1, 1'b1, 1'b1, 16'h0B04, 1};
        tv[15] = '{1'b1, 1'b1, 1'b1, 16'h0B05, 1};
        tv[16] = '{1'b1, 1'b0, 1'b1, 16'h0B06, 1};
        tv[17] = '{1'b1, 1'b0, 1'b1, 16'h0B07, 1};
        tv[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0};

        total = 0;
        bad   = 0;
        for (int k = 0; k < NI; k++) begin
            tail[k]   = 0;
            pushed[k] = 0;
        end
        model_reset();
        m_ready = '0;
        rst_n   = 1'b1;
        #2;
        do_reset();

        // Latency: single word on the latency-1 instance
        m_ready = '1;
        push(1, 16'hA5A5);
        tick();
        check("lat_pop_c0", 1, int'(smp_pop[1]), 1);
        tick();
        check("lat_valid_c1", 1, int'(smp_v[1]), 0);
        tick();
        check("lat_valid_c2", 1, int'(smp_v[1]), 1);
        check("lat_data_c2", 1, int'(smp_d[1]), 16'hA5A5);
        check("lat_pop_c2", 1, int'(smp_pop[1]), 0);
        tick();

        // Streaming: 16 words through the latency-2 instance
        for (int i = 0; i < 16; i++) push(2, DW'(i));
        for (int c = 0; c < 20; c++) begin
            tick();
            check("stream_pop", 2, int'(smp_pop[2]), (c < 16) ? 1 : 0);
            check("stream_valid", 2, int'(smp_v[2]), (c >= 3 && c < 19) ? 1 : 0);
            if (c >= 3 && c < 19) check("stream_data", 2, int'(smp_d[2]), c - 3);
        end

        // Backpressure table
        m_ready[1] = 1'b0;
        for (int i = 0; i < 8; i++) push(1, 16'h0B00 + DW'(i));
        for (int i = 0; i < 19; i++) begin
            m_ready[1] = tv[i].rdy;
            tick();
            check("bp_pop", 1, int'(smp_pop[1]), int'(tv[i].pop));
            check("bp_valid", 1, int'(smp_v[1]), int'(tv[i].vld));
            if (tv[i].vld) check("bp_data", 1, int'(smp_d[1]), int'(tv[i].dat));
        end
        check("bp_count_end", 1, int'(buf_cnt[1]), 0);

        // Empty boundary on the latency-0 instance
        m_ready = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("empty_pop", 0, int'(smp_pop[0]), 0);
            check("empty_valid", 0, int'(smp_v[0]), 0);
        end
        push(0, 16'h3C3C);
        tick();
        check("one_pop", 0, int'(smp_pop[0]), 1);
        check("one_valid_c0", 0, int'(smp_v[0]), 0);
        tick();
        check("one_pop_c1", 0, int'(smp_pop[0]), 0);
        check("one_valid_c1", 0, int'(smp_v[0]), 1);
        check("one_data_c1", 0, int'(smp_d[0]), 16'h3C3C);
        tick();
        check("one_valid_c2", 0, int'(smp_v[0]), 0);

        // Reset mid-stream: two pops in flight, one buffered word
        m_ready[2] = 1'b0;
        for (int i = 0; i < 5; i++) push(2, 16'h5000 + DW'(i));
        tick();
        tick();
        tick();
        check("pre_rst_count", 2, int'(buf_cnt[2]), 1);
        check("pre_rst_inflight", 2, int'(infl[2]), 2);
        do_reset();
        m_ready = '1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_rst_valid", 2, int'(smp_v[2]), 0);
        end
        push(2, 16'h7E7E);
        for (int c = 0; c < 5; c++) tick();
        check("post_rst_drained", 2, out_idx[2], tail[2]);

        // Random ready and arrivals on all instances
        done = 1'b0;
        for (int k = 0; k < NI; k++) pushed[k] = 0;
        cyc = 0;
        while (!done && cyc < 4000) begin
            m_ready = 3'($urandom);
            for (int k = 0; k < NI; k++) begin
                if (pushed[k] < 200 && ($urandom % 2) == 0) begin
                    push(k, DW'($urandom));
                    pushed[k]++;
                end
            end
            tick();
            cyc++;
            done = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (pushed[k] < 200 || out_idx[k] != tail[k]) done = 1'b0;
            end
        end
        for (int k = 0; k < NI; k++) begin
            check("rand_drained", k, out_idx[k], tail[k]);
            check("rand_pushed", k, pushed[k], 200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
